// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes and the receive/transmit FSM state encoding.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick prescaler: counts 0..divisor and ticks on terminal count.
// The divisor tracks i_div while i_hold is low and freezes while it is high.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_hold,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div;

  assign w_div  = i_hold ? r_div : i_div;
  // >= so that shrinking the divisor while idle cannot strand the counter above it
  assign o_tick = (r_cnt >= w_div);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_div <= '0;
    end else begin
      if (!i_hold) r_div <= i_div;
      if (i_clr || o_tick) r_cnt <= '0;
      else                 r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampled UART receiver with majority vote, parity, stop/break checks and a valid/ready holding register.
// rx_valid rises one clock after the last stop-bit decision; a frame finishing while the holder is full is dropped and flagged.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int OVS       = 16,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] SMP_LO  = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] SMP_MID = TW'(OVS/2);
  localparam logic [TW-1:0] SMP_HI  = TW'(OVS/2 + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(OVS - 1);

  logic [1:0]           r_sync;
  uart_state_e          r_state;
  uart_state_e          w_next;
  logic [TW-1:0]        r_tcnt;
  logic [3:0]           r_bcnt;
  logic [1:0]           r_smp;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr_o;
  logic                 r_ferr_o;
  logic                 r_ovr;
  logic                 w_rx_s;
  logic                 w_tick;
  logic                 w_maj;
  logic                 w_dec;
  logic                 w_end;
  logic                 w_done;
  logic                 w_ferr_fin;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], rx};
  end
  assign w_rx_s = r_sync[1];

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (r_state == ST_BREAK),
    .i_hold (r_state != ST_IDLE),
    .i_div  (baud_div),
    .o_tick (w_tick)
  );

  // Majority of the two stored samples and the live third sample.
  assign w_maj      = (r_smp[1] & r_smp[0]) | (r_smp[1] & w_rx_s) | (r_smp[0] & w_rx_s);
  assign w_dec      = w_tick && (r_tcnt == SMP_HI);
  assign w_end      = w_tick && (r_tcnt == T_LAST);
  assign w_ferr_fin = r_ferr | ~w_maj;
  assign w_done     = w_dec && (r_state == ST_STOP) && (r_bcnt == 4'(STOP_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_tick && !w_rx_s) w_next = ST_START;
      ST_START: begin
        if (w_dec && w_maj) w_next = ST_IDLE;
        else if (w_end)     w_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_end && (r_bcnt == 4'(DATA_BITS - 1)))
          w_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (w_end) w_next = ST_STOP;
      // Finish at the last stop-bit decision rather than its end to leave resync margin.
      ST_STOP: begin
        if (w_done) w_next = (w_ferr_fin && (r_shift == '0)) ? ST_BREAK : ST_IDLE;
      end
      ST_BREAK:  if (w_rx_s) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt  <= '0;
      r_bcnt  <= '0;
      r_smp   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) r_tcnt <= '0;
      else if (w_tick)        r_tcnt <= (r_tcnt == T_LAST) ? '0 : r_tcnt + 1'b1;

      if (r_state != w_next) r_bcnt <= '0;
      else if (w_end)        r_bcnt <= r_bcnt + 4'd1;

      if (w_tick && ((r_tcnt == SMP_LO) || (r_tcnt == SMP_MID)))
        r_smp <= {r_smp[0], w_rx_s};

      if (r_state == ST_IDLE) begin
        r_perr <= 1'b0;
        r_ferr <= 1'b0;
      end else if (w_dec) begin
        case (r_state)
          ST_DATA:   r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
          ST_PARITY: r_perr  <= ((^r_shift) ^ w_maj) != (PARITY == PARITY_ODD);
          ST_STOP:   if (!w_maj) r_ferr <= 1'b1;
          default:   ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr_o <= 1'b0;
      r_ferr_o <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_done) begin
        if (!r_valid || rx_ready) begin
          r_data   <= r_shift;
          r_perr_o <= r_perr;
          r_ferr_o <= w_ferr_fin;
          r_valid  <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_perr_o;
  assign frame_err  = r_ferr_o;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs: three instances (8N1, 8E1, 7N2) driven by a bit-level serial line model.
module tb_uart_rx_ovs;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [2:0]  rxl, rdy, vld, perr, ferr, ovr;
  logic [7:0]  dat0, dat1;
  logic [6:0]  dat2;

  int vectors     = 0;
  int miscompares = 0;
  int frames[3]   = '{0, 0, 0};
  int ovr_hi[3]   = '{0, 0, 0};
  logic [2:0] vld_q = 3'b000;

  int NB[3] = '{8, 8, 7};
  int PM[3] = '{0, 2, 0};
  int NS[3] = '{1, 1, 2};

  typedef struct {
    int d;
    int data;
    bit pflip;
    bit stop_low;
    int exp_data;
    bit exp_perr;
    bit exp_ferr;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  uart_rx_ovs #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVS(16), .DIV_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .baud_div(baud_div), .rx(rxl[0]), .rx_data(dat0), .rx_valid(vld[0]),
    .rx_ready(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]));

  uart_rx_ovs #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVS(16), .DIV_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .baud_div(baud_div), .rx(rxl[1]), .rx_data(dat1), .rx_valid(vld[1]),
    .rx_ready(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]));

  uart_rx_ovs #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .OVS(16), .DIV_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .baud_div(baud_div), .rx(rxl[2]), .rx_data(dat2), .rx_valid(vld[2]),
    .rx_ready(rdy[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]));

  // Frame arrivals (valid rising edges) and overrun high cycles per instance.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i] && !vld_q[i]) frames[i]++;
      if (ovr[i]) ovr_hi[i]++;
    end
    vld_q = vld;
  end

  function automatic int bit_clks();
    return 16 * (int'(baud_div) + 1);
  endfunction

  function automatic int dat_of(int d);
    case (d)
      0:       return int'(dat0);
      1:       return int'(dat1);
      default: return int'(dat2);
    endcase
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input int d, input int data, input bit pflip, input bit stop_low);
    int bc;
    bit pb;
    bc = bit_clks();
    rxl[d] = 1'b0;
    wait_clks(bc);
    for (int i = 0; i < NB[d]; i++) begin
      rxl[d] = data[i];
      wait_clks(bc);
    end
    if (PM[d] != 0) begin
      // Even: bit makes the total count of ones even; odd: makes it odd.
      pb = (($countones(data) % 2) == 1) ^ (PM[d] == 1);
      rxl[d] = pb ^ pflip;
      wait_clks(bc);
    end
    for (int i = 0; i < NS[d]; i++) begin
      rxl[d] = !stop_low;
      wait_clks(bc);
    end
    rxl[d] = 1'b1;
    if (stop_low) wait_clks(bc);
  endtask

  task automatic check_frame(input int d, input string name, input int ed, input bit ep, input bit ef);
    int n;
    n = 0;
    while (!vld[d] && n < 2 * bit_clks()) begin
      @(negedge clk);
      n++;
    end
    check({name, " valid"}, int'(vld[d]), 1);
    check({name, " data"}, dat_of(d), ed);
    check({name, " parity_err"}, int'(perr[d]), int'(ep));
    check({name, " frame_err"}, int'(ferr[d]), int'(ef));
    rdy[d] = 1'b1;
    @(negedge clk);
    rdy[d] = 1'b0;
    check({name, " cleared"}, int'(vld[d]), 0);
  endtask

  task automatic partial_then_reset(input int d, input int data);
    int bc;
    bc = bit_clks();
    rxl[d] = 1'b0;
    wait_clks(bc);
    for (int i = 0; i < 4; i++) begin
      rxl[d] = data[i];
      wait_clks(bc);
    end
    rxl[d] = data[4];
    wait_clks(bc / 2);
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    rxl[d] = 1'b1;
    wait_clks(2);
  endtask

  initial begin
    int f0, o0, d, data, bc;
    bit pflip, stop_low;

    vecs[0] = '{d: 0, data: 'hA5, pflip: 0, stop_low: 0, exp_data: 'hA5, exp_perr: 0, exp_ferr: 0};
    vecs[1] = '{d: 1, data: 'h07, pflip: 1, stop_low: 0, exp_data: 'h07, exp_perr: 1, exp_ferr: 0};
    vecs[2] = '{d: 1, data: 'h07, pflip: 0, stop_low: 0, exp_data: 'h07, exp_perr: 0, exp_ferr: 0};
    vecs[3] = '{d: 0, data: 'h3C, pflip: 0, stop_low: 1, exp_data: 'h3C, exp_perr: 0, exp_ferr: 1};

    rst = 1'b1;
    rxl = 3'b111;
    rdy = 3'b000;
    baud_div = 16'd26;
    wait_clks(4);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset%0d valid", i), int'(vld[i]), 0);
      check($sformatf("reset%0d data", i), dat_of(i), 0);
      check($sformatf("reset%0d parity_err", i), int'(perr[i]), 0);
      check($sformatf("reset%0d frame_err", i), int'(ferr[i]), 0);
      check($sformatf("reset%0d overrun", i), int'(ovr[i]), 0);
    end
    rst = 1'b0;
    wait_clks(4);
    bc = bit_clks();

    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].d, vecs[i].data, vecs[i].pflip, vecs[i].stop_low);
      check_frame(vecs[i].d, $sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
    end

    // Start-bit glitch of three ticks must be rejected silently.
    f0 = frames[0];
    rxl[0] = 1'b0;
    wait_clks(3 * 27);
    rxl[0] = 1'b1;
    wait_clks(bc);
    check("glitch valid", int'(vld[0]), 0);
    check("glitch frames", frames[0] - f0, 0);
    send_frame(0, 'h5A, 0, 0);
    check_frame(0, "after_glitch", 'h5A, 0, 0);

    // Break: 20 bit times low gives exactly one all-zero frame with frame_err.
    f0 = frames[0];
    rxl[0] = 1'b0;
    wait_clks(11 * bc);
    check_frame(0, "break", 0, 0, 1);
    wait_clks(9 * bc);
    check("break frames", frames[0] - f0, 1);
    check("break held valid", int'(vld[0]), 0);
    rxl[0] = 1'b1;
    wait_clks(bc);
    send_frame(0, 'hC3, 0, 0);
    check_frame(0, "after_break", 'hC3, 0, 0);

    // Overrun: second frame arrives while the first is still held.
    f0 = frames[0];
    o0 = ovr_hi[0];
    send_frame(0, 'h11, 0, 0);
    send_frame(0, 'h22, 0, 0);
    wait_clks(4);
    check("overrun cycles", ovr_hi[0] - o0, 1);
    check_frame(0, "overrun_kept", 'h11, 0, 0);
    wait_clks(bc);
    check("overrun no second", int'(vld[0]), 0);
    check("overrun frames", frames[0] - f0, 1);

    // Reset in the middle of data bit 4 discards the partial frame.
    partial_then_reset(0, 'h3C);
    check("rst8 valid", int'(vld[0]), 0);
    check("rst8 state", int'(u_dut0.r_state), int'(ST_IDLE));
    wait_clks(bc);
    send_frame(0, 'h3C, 0, 0);
    check_frame(0, "rst8_next", 'h3C, 0, 0);
    partial_then_reset(2, 'h7F);
    check("rst7 valid", int'(vld[2]), 0);
    check("rst7 state", int'(u_dut2.r_state), int'(ST_IDLE));
    wait_clks(bc);
    send_frame(2, 'h7F, 0, 0);
    check_frame(2, "rst7_next", 'h7F, 0, 0);

    // Random frames at random divisors against the line-level model.
    o0 = ovr_hi[0] + ovr_hi[1] + ovr_hi[2];
    for (int k = 0; k < 12; k++) begin
      baud_div = 16'($urandom_range(2, 4));
      d = $urandom_range(0, 2);
      data = int'($urandom) & ((1 << NB[d]) - 1);
      pflip = ($urandom_range(0, 3) == 0);
      stop_low = ($urandom_range(0, 3) == 0);
      wait_clks(40);
      f0 = frames[d];
      send_frame(d, data, pflip, stop_low);
      check_frame(d, $sformatf("rnd%0d", k), data, (PM[d] != 0) && pflip, stop_low);
      wait_clks(2);
      check($sformatf("rnd%0d frames", k), frames[d] - f0, 1);
    end
    check("rnd overrun", ovr_hi[0] + ovr_hi[1] + ovr_hi[2] - o0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
